sst_reg_engine: RTL and testbench

- Initiator side of the mapper save-state (SST) register bus.
- Sequences `sst_act`, `sst_addr`, `sst_we_reg` and `sst_dato` into a mapper, and samples `sst_di` back.
  - Save: dumps the mapper register file into a byte stream.
  - Restore: writes a byte stream back into the mapper.
- Sits between the save-state DMA/host logic and the active mapper's SST port.
- Restore writes are timed against the CPU M2 clock, because mappers latch SST writes on the M2 falling edge.

---
 rtl/sst_reg_engine.sv | 176 +++++++++++++++++
 tb/tb_sst_reg_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sst_reg_engine.sv
// Initiator for the mapper save-state register bus: streams the register file out (save)
// or writes a byte stream back into it (restore), with writes timed against M2 falling edges.
module sst_reg_engine #(
   parameter int unsigned N_REGS = 128,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned M2_TMO = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       m2,
   input  logic       start_save,
   input  logic       start_load,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       sst_act,
   output logic [7:0] sst_addr,
   output logic       sst_we_reg,
   output logic [7:0] sst_dato,
   input  logic [7:0] sst_di,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned CntMax = (M2_TMO > SETTLE) ? M2_TMO : SETTLE;
   localparam int unsigned CntW = $clog2(CntMax + 1);
   localparam logic [7:0] LastAddr = 8'(N_REGS - 1);
   localparam logic [CntW-1:0] SettleCnt = CntW'(SETTLE);
   localparam logic [CntW-1:0] TmoCnt = CntW'(M2_TMO - 1);

   typedef enum logic [2:0] {
      StIdle, StSSet, StSOut, StLIn, StLWr, StLChk, StFin
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      addr_q, addr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            hold_q, hold_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic [7:0]      dato_q, dato_d;
   logic            err_q, err_d;
   logic            m2_s1_q, m2_s2_q, m2_h_q;
   logic            m2_fall;

   assign m2_fall = m2_h_q & ~m2_s2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         cnt_q       <= '0;
         hold_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         dato_q      <= '0;
         err_q       <= 1'b0;
         m2_s1_q     <= 1'b0;
         m2_s2_q     <= 1'b0;
         m2_h_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         dato_q      <= dato_d;
         err_q       <= err_d;
         m2_s1_q     <= m2;
         m2_s2_q     <= m2_s1_q;
         m2_h_q      <= m2_s2_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      dato_d      = dato_q;
      err_d       = err_q;
      in_ready    = 1'b0;
      sst_we_reg  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_save) begin
               state_d = StSSet;
               addr_d  = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
            end else if (start_load) begin
               state_d = StLIn;
               addr_d  = '0;
               err_d   = 1'b0;
            end
         end
         StSSet: begin
            if (cnt_q == SettleCnt) begin
               out_data_d  = sst_di;
               out_valid_d = 1'b1;
               state_d     = StSOut;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StSOut: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = '0;
               if (addr_q == LastAddr) begin
                  state_d = StFin;
               end else begin
                  addr_d  = addr_q + 8'd1;
                  state_d = StSSet;
               end
            end
         end
         StLIn: begin
            in_ready = 1'b1;
            if (in_valid) begin
               dato_d  = in_data;
               cnt_d   = '0;
               hold_d  = 1'b0;
               state_d = (addr_q == LastAddr) ? StLChk : StLWr;
            end
         end
         StLWr: begin
            sst_we_reg = 1'b1;
            // Keep the strobe one extra cycle after the synced fall is seen.
            if (hold_q) begin
               hold_d  = 1'b0;
               addr_d  = addr_q + 8'd1;
               state_d = StLIn;
            end else if (m2_fall) begin
               hold_d = 1'b1;
            end else if (cnt_q == TmoCnt) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StLChk: begin
            // Index register is read-only: verify instead of writing.
            if (cnt_q == SettleCnt) begin
               if (sst_di != dato_q) err_d = 1'b1;
               state_d = StFin;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StFin: begin
            addr_d  = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign sst_act   = rst_n && (state_q != StIdle) && (state_q != StFin);
   assign sst_addr  = addr_q;
   assign sst_dato  = dato_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StFin);
   assign err       = err_q;

endmodule

// File: tb/tb_sst_reg_engine.sv
// Directed bench for sst_reg_engine with a mapper register-file model and a per-cycle monitor.
`timescale 1ns/1ps
module tb_sst_reg_engine;

   logic       clk = 1'b0;
   logic       rst_n, m2, start_save, start_load;
   logic [7:0] out_data, in_data, sst_addr, sst_dato, sst_di;
   logic       out_valid, out_ready, in_valid, in_ready;
   logic       sst_act, sst_we_reg, busy, done, err;

   sst_reg_engine dut (
      .clk(clk), .rst_n(rst_n), .m2(m2), .start_save(start_save), .start_load(start_load),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sst_act(sst_act), .sst_addr(sst_addr), .sst_we_reg(sst_we_reg), .sst_dato(sst_dato),
      .sst_di(sst_di), .busy(busy), .done(done), .err(err)
   );

   always #10 clk = ~clk;

   // Free-running M2 around 1.79 MHz, asynchronous to the 50 MHz clk.
   logic m2_run = 1'b0;
   initial m2 = 1'b1;
   always begin
      #279.33;
      if (m2_run) m2 = ~m2;
      else m2 = 1'b1;
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Mapper model: save mode reads addr^5A; restore mode reads back the written file.
   logic       save_mode;
   logic [7:0] map_idx;
   logic [7:0] regs [0:127];
   int         wr_cnt [0:127];
   assign sst_di = save_mode ? (sst_addr ^ 8'h5A) :
                   (sst_addr == 8'd127) ? map_idx : regs[sst_addr[6:0]];

   logic b_s1 = 1'b0, b_s2 = 1'b0, b_h = 1'b0;
   always @(posedge clk) begin
      b_h  <= b_s2;
      b_s2 <= b_s1;
      b_s1 <= m2;
   end

   int         sv_idx, busy_cycles, done_cnt, win_len, tmo_windows, tmo_len;
   logic       win_fall, we_prev, prev_valid, prev_ready, expect_tmo;
   logic [7:0] addr_prev, dato_prev, prev_data, prev_addr;

   always @(negedge clk) begin
      if (!rst_n) begin
         we_prev    = 1'b0;
         prev_valid = 1'b0;
         win_len    = 0;
         win_fall   = 1'b0;
      end else begin
         chk("sst_act", sst_act, busy & ~done);
         if (save_mode) begin
            chk("save_no_we", sst_we_reg, 0);
            chk("save_no_in_ready", in_ready, 0);
         end
         if (busy) busy_cycles++;
         if (done) done_cnt++;
         if (prev_valid && !prev_ready) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_addr", sst_addr, prev_addr);
         end
         if (out_valid && out_ready) begin
            chk("save_data", out_data, (sv_idx ^ 8'h5A) & 8'hFF);
            chk("save_addr", sst_addr, sv_idx);
            if (sv_idx == 0) chk("lit_byte0", out_data, 8'h5A);
            if (sv_idx == 2) chk("lit_byte2", out_data, 8'h58);
            if (sv_idx == 127) chk("lit_byte127", out_data, 8'h25);
            sv_idx++;
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_addr  = sst_addr;
         if (sst_we_reg) begin
            if (we_prev) begin
               chk("we_addr_stable", sst_addr, addr_prev);
               chk("we_dato_stable", sst_dato, dato_prev);
            end
            win_len++;
            if (b_h && !b_s2) win_fall = 1'b1;
            addr_prev = sst_addr;
            dato_prev = sst_dato;
         end else if (we_prev) begin
            if (win_fall) begin
               regs[addr_prev[6:0]] = dato_prev;
               wr_cnt[addr_prev[6:0]]++;
               chk("we_window_len_ge2", win_len >= 2, 1);
            end else begin
               chk("we_window_has_m2_fall", expect_tmo, 1);
               tmo_windows++;
               tmo_len = win_len;
            end
            win_len  = 0;
            win_fall = 1'b0;
         end
         we_prev = sst_we_reg;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      chk(name, {sst_act, busy, done, err, out_valid, in_ready, sst_we_reg, sst_addr, out_data,
                 sst_dato}, 0);
   endtask

   task automatic pulse(input logic s, input logic l);
      tick();
      start_save = s;
      start_load = l;
      tick();
      start_save = 1'b0;
      start_load = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int n;
      for (n = 0; n < max_cyc; n++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done_in_time", n < max_cyc, 1);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      for (n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      chk("in_handshake", n < 2000, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 128; i++) begin
         regs[i]   = 8'hFF;
         wr_cnt[i] = 0;
      end
      sv_idx = 0; busy_cycles = 0; done_cnt = 0; tmo_windows = 0; tmo_len = 0;
   endtask

   task automatic restore(input logic [7:0] last);
      pulse(1'b0, 1'b1);
      for (int a = 0; a < 127; a++) send(8'(a));
      send(last);
      wait_done(8000);
   endtask

   task automatic check_regs(input string name);
      int bad = 0;
      for (int a = 0; a < 127; a++) if (regs[a] != 8'(a) || wr_cnt[a] != 1) bad++;
      chk(name, bad, 0);
      chk({name, "_r5"}, regs[5], 8'h05);
      chk({name, "_r126"}, regs[126], 8'h7E);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start_save = 1'b0; start_load = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_data = 8'h00; save_mode = 1'b1; map_idx = 8'h86; expect_tmo = 1'b0;
      clear_model();
      repeat (3) tick();
      check_zero("reset_outputs");
      rst_n = 1'b1;

      // Save with continuous ready: 128 bytes at SETTLE+2 cycles each plus FIN.
      clear_model();
      pulse(1'b1, 1'b0);
      wait_done(1000);
      repeat (2) tick();
      chk("save1_bytes", sv_idx, 128);
      chk("save1_done_once", done_cnt, 1);
      chk("save1_busy_cycles", busy_cycles, 128 * 4 + 1);
      chk("save1_err", err, 0);

      // Save with a 10-cycle stall on byte 3.
      clear_model();
      pulse(1'b1, 1'b0);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (sst_addr == 8'd3 && !out_valid) break;
      end
      tick();
      out_ready = 1'b0;
      repeat (10) tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'h59);
      chk("bp_addr", sst_addr, 3);
      out_ready = 1'b1;
      wait_done(1000);
      repeat (2) tick();
      chk("save2_bytes", sv_idx, 128);
      chk("save2_done_once", done_cnt, 1);

      // Restore with matching index.
      save_mode = 1'b0;
      m2_run = 1'b1;
      clear_model();
      restore(8'h86);
      chk("restore_err", err, 0);
      repeat (2) tick();
      check_regs("restore_regs");
      chk("restore_done_once", done_cnt, 1);

      // Restore with mismatching index byte.
      clear_model();
      restore(8'h42);
      chk("mismatch_err", err, 1);
      repeat (2) tick();
      check_regs("mismatch_regs");
      chk("mismatch_done_once", done_cnt, 1);
      chk("err_sticky_idle", err, 1);

      // M2 stopped: the first write must time out.
      m2_run = 1'b0;
      repeat (40) tick();
      clear_model();
      expect_tmo = 1'b1;
      pulse(1'b0, 1'b1);
      chk("err_cleared_by_start", err, 0);
      send(8'h11);
      wait_done(6000);
      chk("tmo_err", err, 1);
      chk("tmo_act_low", sst_act, 0);
      chk("tmo_we_low", sst_we_reg, 0);
      repeat (2) tick();
      chk("tmo_windows", tmo_windows, 1);
      chk("tmo_len", tmo_len, 4096);
      chk("tmo_no_write", wr_cnt[0], 0);
      chk("tmo_done_once", done_cnt, 1);
      expect_tmo = 1'b0;

      // Reset during save byte 40, then a dual start must run a save.
      save_mode = 1'b1;
      clear_model();
      pulse(1'b1, 1'b0);
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (sv_idx == 40) break;
      end
      chk("reached_byte40", sv_idx, 40);
      tick();
      rst_n = 1'b0;
      start_save = 1'b1;
      start_load = 1'b1;
      @(negedge clk);
      chk("rst_act_same_cycle", sst_act, 0);
      tick();
      check_zero("rst_mid_outputs");
      clear_model();
      rst_n = 1'b1;
      tick();
      start_save = 1'b0;
      start_load = 1'b0;
      chk("dual_start_busy", busy, 1);
      chk("dual_start_act", sst_act, 1);
      chk("dual_start_no_in_ready", in_ready, 0);
      wait_done(1000);
      repeat (2) tick();
      chk("dual_bytes", sv_idx, 128);
      chk("dual_done_once", done_cnt, 1);
      chk("dual_busy_cycles", busy_cycles, 128 * 4 + 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
